// File: rtl/data_mem_pkg.sv
// Shared types and default configuration for the parametrised data memory.
// The request struct describes the default-width request as seen by users of the block.
package data_mem_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int DEPTH_DEF   = 4112;
    localparam int LATENCY_DEF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic                      rw;
        logic [ADDR_W_DEF-1:0]     addr;
        logic [DATA_W_DEF-1:0]     wdata;
        logic [DATA_W_DEF/8-1:0]   be;
    } req_t;

endpackage

// File: rtl/data_mem_array.sv
// Byte-enabled single-port storage with a registered one-cycle read port.
// Contents are never reset; word 1 starts at 1 in simulation.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH_DEF)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

`ifndef SYNTHESIS
    initial mem[1] = DATA_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/param_data_memory.sv
// Memory-stage data memory: request/response handshake, programmable wait states,
// byte write enables and an out-of-range error response around data_mem_array.
module param_data_memory
    import data_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              ready_q;
    logic              rsp_rd_q;
    logic              rsp_err_q;

    logic              cap_rw;
    logic              cap_oor;
    logic [AW-1:0]     cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [BE_W-1:0]   cap_be;

    logic              accept;
    logic              last_wait;
    logic              arr_en;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    // WAIT spends LATENCY wait cycles (cnt 0..LATENCY-1) plus one access cycle
    // (cnt == LATENCY) whose closing edge performs the access and enters RESP.
    assign accept    = (state == IDLE) && ready_q && req_valid;
    assign last_wait = (state == WAIT) && (cnt == CNT_LAST);
    assign arr_en    = last_wait && !cap_oor && !rst;
    assign arr_we    = arr_en && cap_rw;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = WAIT;
            WAIT:    if (last_wait) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, wait counter, ready and response flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ready_q   <= 1'b0;
            rsp_rd_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
            if (state == WAIT) begin
                cnt <= last_wait ? '0 : cnt + CW'(1);
            end
            if (last_wait) begin
                rsp_rd_q  <= !cap_rw && !cap_oor;
                rsp_err_q <= cap_oor;
            end
        end
    end

    // Request capture; the range check is resolved here on the full-width address
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_rw    <= req_rw;
            cap_oor   <= (64'(req_addr) >= 64'(DEPTH));
            cap_addr  <= req_addr[AW-1:0];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk    (clk),
        .en     (arr_en),
        .we     (arr_we),
        .be     (cap_be),
        .addr   (cap_addr),
        .wdata  (cap_wdata),
        .rdata  (arr_rdata)
    );

    // The array only reads in the access cycle, so its output holds through RESP
    assign req_ready = ready_q;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_rd_q ? arr_rdata : '0;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: a LATENCY=0 and a LATENCY=3 instance share clock and reset;
// a vector table plus hand-written backpressure and reset-abort sequences feed a scoreboard.
module tb_param_data_memory;
    import data_mem_pkg::*;

    typedef struct packed {
        logic        sel;
        req_t        req;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rw = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b1;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    param_data_memory #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    param_data_memory #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(b_req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic rw, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.sel       = s;
        v.req.rw    = rw;
        v.req.addr  = addr;
        v.req.wdata = wdata;
        v.req.be    = be;
        v.exp_rdata = erd;
        v.exp_err   = eerr;
        return v;
    endfunction

    task automatic wait_ready(input string tag, output logic ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) check({tag, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
    endtask

    // Issue one request, push its expectation, then check latency, data and handshake.
    task automatic run_vec(input vec_t v, input int hold, input string tag);
        logic ok;
        int   n;
        exp_t e;
        logic [31:0] rd0;
        sel       = v.sel;
        rsp_ready = (hold == 0);
        wait_ready(tag, ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_rw    = v.req.rw;
        req_addr  = v.req.addr;
        req_wdata = v.req.wdata;
        req_be    = v.req.be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_addr  = $urandom_range(0, 4111);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, v.sel ? 32'd4 : 32'd1);
        if (rsp_valid !== 1'b1) begin
            void'(sb.pop_front());
            rsp_ready = 1'b1;
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
        rd0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_hold%0d_valid", tag, i), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("%s_hold%0d_rdata", tag, i), rsp_rdata, rd0);
            check($sformatf("%s_hold%0d_ready", tag, i), {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_rsp_done"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    // Write on the LATENCY=3 instance, then reset after `delay` edges spent in WAIT.
    task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata,
                               input int delay, input string tag);
        logic ok;
        logic seen = 1'b0;
        sel       = 1'b1;
        rsp_ready = 1'b1;
        wait_ready(tag, ok);
        if (!ok) return;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (delay) begin
            @(posedge clk); #1;
        end
        check({tag, "_busy"}, {31'b0, b_req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b_rsp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        check({tag, "_no_rsp"}, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[16];
        vecs[0]  = mk(0, 0, 32'd1,        32'h0,        4'h0, 32'h0000_0001, 0);
        vecs[1]  = mk(0, 1, 32'd10,       32'hAABBCCDD, 4'hF, 32'h0,         0);
        vecs[2]  = mk(0, 1, 32'd10,       32'h11223344, 4'h5, 32'h0,         0);
        vecs[3]  = mk(0, 0, 32'd10,       32'h0,        4'h0, 32'hAA22CC44,  0);
        vecs[4]  = mk(0, 1, 32'd4111,     32'hCAFEF00D, 4'hF, 32'h0,         0);
        vecs[5]  = mk(0, 0, 32'd4112,     32'h0,        4'hF, 32'h0,         1);
        vecs[6]  = mk(0, 1, 32'd5000,     32'h12345678, 4'hF, 32'h0,         1);
        vecs[7]  = mk(0, 0, 32'd4111,     32'h0,        4'h0, 32'hCAFEF00D,  0);
        vecs[8]  = mk(0, 1, 32'd10,       32'h0,        4'h0, 32'h0,         0);
        vecs[9]  = mk(0, 0, 32'd10,       32'h0,        4'h0, 32'hAA22CC44,  0);
        vecs[10] = mk(0, 1, 32'd10,       32'hFFFFFFFF, 4'hA, 32'h0,         0);
        vecs[11] = mk(0, 0, 32'd10,       32'h0,        4'h0, 32'hFF22FF44,  0);
        vecs[12] = mk(0, 0, 32'hFFFFFFFF, 32'h0,        4'h0, 32'h0,         1);
        vecs[13] = mk(1, 1, 32'd20,       32'h01020304, 4'hF, 32'h0,         0);
        vecs[14] = mk(1, 0, 32'd20,       32'h0,        4'h0, 32'h01020304,  0);
        vecs[15] = mk(1, 0, 32'd4200,     32'h0,        4'h0, 32'h0,         1);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", {31'b0, a_req_ready}, 32'd0);
        check("rst_ready3", {31'b0, b_req_ready}, 32'd0);
        check("rst_valid0", {31'b0, a_rsp_valid}, 32'd0);
        check("rst_valid3", {31'b0, b_rsp_valid}, 32'd0);
        check("rst_rdata0", a_rsp_rdata, 32'd0);
        check("rst_err3",   {31'b0, b_rsp_err}, 32'd0);
        rst = 1'b0;
        check("rst_release_ready", {31'b0, a_req_ready}, 32'd0);
        @(posedge clk); #1;
        check("post_rst_ready0", {31'b0, a_req_ready}, 32'd1);
        check("post_rst_ready3", {31'b0, b_req_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], 0, $sformatf("v%0d", i));

        run_vec(mk(1, 0, 32'd20, 32'h0, 4'h0, 32'h01020304, 0), 5, "bp_read");
        run_vec(mk(0, 1, 32'd12, 32'h5A5A5A5A, 4'hF, 32'h0, 0), 3, "bp_write");
        run_vec(mk(0, 0, 32'd12, 32'h0, 4'h0, 32'h5A5A5A5A, 0), 0, "bp_readback");

        abort_write(32'd20, 32'hDEADBEEF, 1, "abort_w2");
        run_vec(mk(1, 0, 32'd20, 32'h0, 4'h0, 32'h01020304, 0), 0, "abort_w2_read");
        abort_write(32'd20, 32'hBAADF00D, 3, "abort_last");
        run_vec(mk(1, 0, 32'd20, 32'h0, 4'h0, 32'h01020304, 0), 0, "abort_last_read");
        run_vec(mk(0, 0, 32'd10, 32'h0, 4'h0, 32'hFF22FF44, 0), 0, "mem_kept_read");

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
